// File: rtl/frame_store_pkg.sv
// Shared geometry, colour and FSM definitions for the frame store.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package frame_store_pkg;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int XW     = 8;
    localparam int YW     = 7;
    localparam int CW     = 3;
    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int AW     = $clog2(DEPTH);

    localparam logic [CW-1:0] BG_COLOR = '0;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fs_state_t;

    // Linear pixel address, row-major.
    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px,
                                               input logic [YW-1:0] py);
        return AW'(py) * AW'(WIDTH) + AW'(px);
    endfunction

    // True when the coordinate lies inside the visible frame.
    function automatic logic in_frame(input logic [XW-1:0] px,
                                      input logic [YW-1:0] py);
        return (px <= X_LAST) && (py <= Y_LAST);
    endfunction

endpackage

// File: rtl/frame_store_pixel_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Latency: read data valid the cycle after a read enable; write lands at the edge.
// Backpressure: none; read data holds while no read is enabled.
module frame_store_pixel_ram #(
    parameter int DW    = 3,
    parameter int AW    = 15,
    parameter int DEPTH = 19200
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_vld,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read port; output holds between reads.
    always_ff @(posedge clk) begin
        if (rd_vld) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/frame_store.sv
// Pixel frame store: clears to background, takes plots, answers obstacle probes, streams raster scan-out.
// Latency: probe answers one cycle after request; scan pixel presented one cycle after its read issues.
// Backpressure: plots/probes never stall; scan-out holds on !pix_ready and probes pre-empt scan reads.
// Build option: FRAME_STORE_BOUNDARY_WALL_EN makes the frame border and beyond report as obstacles.
module frame_store
    import frame_store_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          plot,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [CW-1:0] color,
    input  logic          query,
    input  logic [XW-1:0] qx,
    input  logic [YW-1:0] qy,
    output logic          obstacle,
    output logic          q_valid,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_color,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start
);

    fs_state_t     state_q, state_d;
    logic [AW-1:0] clr_cnt_q;
    logic          busy_q;

    // RAM port controls
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [CW-1:0] ram_wd;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [CW-1:0] ram_rdat;

    // Same-cycle write/read bypass
    logic          byp_q;
    logic [CW-1:0] byp_dat_q;
    logic [CW-1:0] rd_dat;

    // Probe pipeline
    logic          q_vld_q;
    logic          q_rd_q;
    logic          q_wall_q;
    logic          q_wall;
    logic          obst_now;
    logic          obst_hold_q;

    // Scan-out
    logic          scan_issue;
    logic [XW-1:0] scan_x_q;
    logic [YW-1:0] scan_y_q;
    logic          pix_vld_q;
    logic [XW-1:0] pix_x_q;
    logic [YW-1:0] pix_y_q;
    logic          frame_start_q;
    logic          scan_land_q;
    logic [CW-1:0] pix_hold_q;

    logic [AW-1:0] plot_addr;
    logic [AW-1:0] query_addr;
    logic [AW-1:0] scan_addr;
    logic          query_in_frame;

    assign plot_addr      = pix_addr(x, y);
    assign query_addr     = pix_addr(qx, qy);
    assign scan_addr      = pix_addr(scan_x_q, scan_y_q);
    assign query_in_frame = in_frame(qx, qy);

`ifdef FRAME_STORE_BOUNDARY_WALL_EN
    assign q_wall = (qx == '0) || (qx >= X_LAST) || (qy == '0) || (qy >= Y_LAST);
`else
    assign q_wall = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave CLEAR once the last address has been written
    always_comb begin
        state_d = state_q;
        if ((state_q == CLEAR) && (clr_cnt_q == A_LAST)) begin
            state_d = RUN;
        end
    end

    // FSM outputs: RAM port steering, probe acceptance and scan issue
    always_comb begin
        ram_we     = 1'b0;
        ram_wa     = plot_addr;
        ram_wd     = color;
        ram_re     = 1'b0;
        ram_ra     = scan_addr;
        scan_issue = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_we = 1'b1;
                ram_wa = clr_cnt_q;
                ram_wd = BG_COLOR;
            end
            RUN: begin
                ram_we     = plot && in_frame(x, y);
                scan_issue = !query && (!pix_vld_q || pix_ready);
                if (query) begin
                    ram_re = query_in_frame;
                    ram_ra = query_addr;
                end else begin
                    ram_re = scan_issue;
                end
            end
            default: begin
            end
        endcase
    end

    // Clear address counter and busy flag; busy falls with the move to RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            busy_q <= (state_d == CLEAR);
        end
    end

    frame_store_pixel_ram #(
        .DW    (CW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_vld  (ram_we),
        .wr_addr (ram_wa),
        .wr_dat  (ram_wd),
        .rd_vld  (ram_re),
        .rd_addr (ram_ra),
        .rd_dat  (ram_rdat)
    );

    // Capture a write that hits the address being read so the reader sees the new colour
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_q     <= 1'b0;
            byp_dat_q <= '0;
        end else begin
            byp_q     <= ram_we && ram_re && (ram_wa == ram_ra);
            byp_dat_q <= ram_wd;
        end
    end

    assign rd_dat = byp_q ? byp_dat_q : ram_rdat;

    // Probe pipeline: remember whether memory was read and whether the wall applies
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_vld_q     <= 1'b0;
            q_rd_q      <= 1'b0;
            q_wall_q    <= 1'b0;
            obst_hold_q <= 1'b0;
        end else begin
            q_vld_q  <= query && (state_q == RUN);
            q_rd_q   <= query_in_frame;
            q_wall_q <= q_wall;
            if (q_vld_q) begin
                obst_hold_q <= obst_now;
            end
        end
    end

    // The RAM output register is shared with scan-out, so the answer is latched for holding
    assign obst_now = q_wall_q || (q_rd_q && (rd_dat != BG_COLOR));
    assign obstacle = q_vld_q ? obst_now : obst_hold_q;
    assign q_valid  = q_vld_q;

    // Scan-out: raster counters advance per issued read; output register holds under stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_x_q      <= '0;
            scan_y_q      <= '0;
            pix_vld_q     <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            scan_land_q   <= 1'b0;
            pix_hold_q    <= '0;
        end else begin
            scan_land_q <= scan_issue;
            if (scan_land_q) begin
                pix_hold_q <= rd_dat;
            end
            if (scan_issue) begin
                pix_vld_q     <= 1'b1;
                pix_x_q       <= scan_x_q;
                pix_y_q       <= scan_y_q;
                frame_start_q <= (scan_x_q == '0) && (scan_y_q == '0);
                if (scan_x_q == X_LAST) begin
                    scan_x_q <= '0;
                    scan_y_q <= (scan_y_q == Y_LAST) ? '0 : scan_y_q + 1'b1;
                end else begin
                    scan_x_q <= scan_x_q + 1'b1;
                end
            end else if (pix_ready) begin
                pix_vld_q     <= 1'b0;
                frame_start_q <= 1'b0;
            end
        end
    end

    assign busy        = busy_q;
    assign pix_valid   = pix_vld_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign pix_color   = scan_land_q ? rd_dat : pix_hold_q;

endmodule

// File: tb/tb_frame_store.sv
// Directed bench for frame_store with a queue scoreboard for probes and a raster model for scan-out.
// Latency: probes checked for exactly one cycle of latency; scan pixels checked in acceptance order.
// Backpressure: pix_ready is stalled and released to check hold-stable output and lossless raster order.
module tb_frame_store;

    logic       clk;
    logic       reset;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       query;
    logic [7:0] qx;
    logic [6:0] qy;
    logic       obstacle;
    logic       q_valid;
    logic       busy;
    logic       pix_valid;
    logic       pix_ready;
    logic [2:0] pix_color;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       frame_start;

    frame_store dut (
        .clk         (clk),
        .reset       (reset),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .color       (color),
        .query       (query),
        .qx          (qx),
        .qy          (qy),
        .obstacle    (obstacle),
        .q_valid     (q_valid),
        .busy        (busy),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_color   (pix_color),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_bad;
    int cyc_cnt;
    int acc_cnt;
    bit frame_wrap;

    logic [2:0] img [0:19199];
    bit         exp_o [$];
    int         exp_c [$];

    initial begin
        cyc_cnt = 0;
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    function automatic bit exp_obst(input int qxx, input int qyy);
`ifdef FRAME_STORE_BOUNDARY_WALL_EN
        if (qxx == 0 || qxx >= 159 || qyy == 0 || qyy >= 119) return 1'b1;
`endif
        if (qxx >= 160 || qyy >= 120) return 1'b0;
        return img[qyy * 160 + qxx] != 3'd0;
    endfunction

    // One stimulus cycle: optional plot and optional probe, expectations queued at issue.
    task automatic step(input bit p, input int px, input int py, input int pc,
                        input bit q, input int qxx, input int qyy);
        @(posedge clk);
        #1;
        plot  = p;
        x     = px[7:0];
        y     = py[6:0];
        color = pc[2:0];
        query = q;
        qx    = qxx[7:0];
        qy    = qyy[6:0];
        if (p && px < 160 && py < 120) img[py * 160 + px] = pc[2:0];
        if (q) begin
            exp_o.push_back(exp_obst(qxx, qyy));
            exp_c.push_back(cyc_cnt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    // Monitor: pops probe expectations on q_valid, checks scan pixels on each handshake.
    initial begin
        int sx, sy;
        bit stall_prev;
        logic [7:0] prev_x;
        logic [6:0] prev_y;
        logic [2:0] prev_c;
        sx = 0;
        sy = 0;
        stall_prev = 1'b0;
        prev_x = '0;
        prev_y = '0;
        prev_c = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sx = 0;
                sy = 0;
                stall_prev = 1'b0;
            end else begin
                if (q_valid) begin
                    chk("q_valid_expected", (exp_o.size() > 0) ? 1 : 0, 1);
                    if (exp_o.size() > 0) begin
                        bit eo;
                        int ec;
                        eo = exp_o.pop_front();
                        ec = exp_c.pop_front();
                        chk("q_obstacle", int'(obstacle), int'(eo));
                        chk("q_latency", cyc_cnt, ec + 1);
                    end
                end
                if (stall_prev) begin
                    chk("stall_x", int'(pix_x), int'(prev_x));
                    chk("stall_y", int'(pix_y), int'(prev_y));
                    chk("stall_color", int'(pix_color), int'(prev_c));
                end
                if (pix_valid && pix_ready) begin
                    chk("scan_x", int'(pix_x), sx);
                    chk("scan_y", int'(pix_y), sy);
                    chk("scan_color", int'(pix_color), int'(img[sy * 160 + sx]));
                    chk("scan_frame_start", int'(frame_start), (sx == 0 && sy == 0) ? 1 : 0);
                    if (sx == 0 && sy == 0 && acc_cnt > 0) frame_wrap = 1'b1;
                    acc_cnt++;
                    if (sx == 159) begin
                        sx = 0;
                        sy = (sy == 119) ? 0 : sy + 1;
                    end else begin
                        sx++;
                    end
                end
                stall_prev = pix_valid && !pix_ready;
                prev_x = pix_x;
                prev_y = pix_y;
                prev_c = pix_color;
            end
        end
    end

    initial begin
        int n_busy;
        int a0;
        bit found;
        n_vec = 0;
        n_bad = 0;
        acc_cnt = 0;
        frame_wrap = 1'b0;
        for (int i = 0; i < 19200; i++) img[i] = 3'd0;
        reset = 1'b0;
        plot = 1'b0; x = '0; y = '0; color = '0;
        query = 1'b0; qx = '0; qy = '0;
        pix_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obstacle", int'(obstacle), 0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_color", int'(pix_color), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        reset = 1'b1;

        // Reset again once the clear has reached address 5000
        repeat (5000) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("midclr_busy", int'(busy), 1);
        chk("midclr_pix_valid", int'(pix_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Full clear length; a plot and a probe issued during clear must be ignored
        n_busy = 0;
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (i == 19000) begin
                plot = 1'b1; x = 8'd0; y = 7'd0; color = 3'd7;
                query = 1'b1; qx = 8'd5; qy = 7'd5;
            end else begin
                plot = 1'b0;
                query = 1'b0;
            end
            if (busy) n_busy++;
            else break;
        end
        chk("busy_cycles", n_busy, 19200);
        idle(2);

        // Probes after clear, then plot/probe
        step(1'b0, 0, 0, 0, 1'b1, 10, 20);
        step(1'b0, 0, 0, 0, 1'b1, 100, 100);
        step(1'b1, 10, 20, 5, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b1, 10, 20);
        step(1'b0, 0, 0, 0, 1'b1, 11, 20);
        step(1'b0, 0, 0, 0, 1'b1, 10, 20);
        idle(3);
        chk("obst_hold", int'(obstacle), 1);

        // Same-cycle plot and probe collisions
        step(1'b1, 3, 3, 2, 1'b1, 3, 3);
        step(1'b1, 3, 3, 0, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b1, 3, 3);
        step(1'b1, 3, 3, 6, 1'b1, 3, 3);
        step(1'b1, 3, 3, 0, 1'b1, 3, 3);

        // Out-of-range plot is dropped (would alias to (40,51)); border probes
        step(1'b1, 200, 50, 7, 1'b0, 0, 0);
        step(1'b0, 0, 0, 0, 1'b1, 200, 50);
        step(1'b0, 0, 0, 0, 1'b1, 40, 51);
        step(1'b0, 0, 0, 0, 1'b1, 0, 40);
        step(1'b0, 0, 0, 0, 1'b1, 159, 119);
        step(1'b0, 0, 0, 0, 1'b1, 0, 0);
        idle(3);

        // Stream until (159,0) is presented, then stall for 10 cycles
        pix_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (pix_valid && pix_x == 8'd159 && pix_y == 7'd0) begin
                pix_ready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        chk("bp_reach_159_0", int'(found), 1);
        repeat (10) @(posedge clk);
        #1;
        pix_ready = 1'b1;

        // Sustained throughput with no probes
        repeat (5) @(posedge clk);
        a0 = acc_cnt;
        repeat (100) @(posedge clk);
        chk("stream_rate", acc_cnt - a0, 100);

        // Run through the frame wrap
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (frame_wrap) break;
        end
        chk("frame_wrap", int'(frame_wrap), 1);

        // Probes every other cycle against a running scan
        a0 = acc_cnt;
        for (int i = 0; i < 200; i++) begin
            if (i == 50) step(1'b0, 0, 0, 0, 1'b1, 10, 20);
            else step(1'b0, 0, 0, 0, 1'b1, (i * 7) % 170, (i * 3) % 125);
            step(1'b0, 0, 0, 0, 1'b0, 0, 0);
        end
        chk("qs_throughput", ((acc_cnt - a0) >= 198 && (acc_cnt - a0) <= 201) ? 1 : 0, 1);
        idle(5);
        chk("q_drain", exp_o.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
